// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: CPU MEM-stage port, loader/DMA port and RAM side.
// With DMEM_ARB_STATS_EN defined it also carries the grant/stall statistics counters.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic              i_cpu_req;
    logic              i_cpu_we;
    logic [ADDR_W-1:0] i_cpu_addr;
    logic [DATA_W-1:0] i_cpu_wdata;
    logic [DATA_W-1:0] o_cpu_rdata;
    logic              o_cpu_gnt;
    logic              o_cpu_stall;

    logic              i_dma_req;
    logic              i_dma_we;
    logic              i_dma_lock;
    logic [ADDR_W-1:0] i_dma_addr;
    logic [DATA_W-1:0] i_dma_wdata;
    logic [DATA_W-1:0] o_dma_rdata;
    logic              o_dma_rvalid;
    logic              o_dma_gnt;

    logic [ADDR_W-1:0] o_ram_addr;
    logic [DATA_W-1:0] o_ram_wdata;
    logic              o_ram_we;
    logic [DATA_W-1:0] i_ram_rdata;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0]       o_cpu_cnt;
    logic [15:0]       o_dma_cnt;
    logic [15:0]       o_stall_cnt;
`endif

    modport slave (
        input  i_cpu_req, input i_cpu_we, input i_cpu_addr, input i_cpu_wdata,
        input  i_dma_req, input i_dma_we, input i_dma_lock, input i_dma_addr, input i_dma_wdata,
        input  i_ram_rdata,
        output o_cpu_rdata, output o_cpu_gnt, output o_cpu_stall,
        output o_dma_rdata, output o_dma_rvalid, output o_dma_gnt,
        output o_ram_addr, output o_ram_wdata, output o_ram_we
`ifdef DMEM_ARB_STATS_EN
        , output o_cpu_cnt, output o_dma_cnt, output o_stall_cnt
`endif
    );

    modport master (
        output i_cpu_req, output i_cpu_we, output i_cpu_addr, output i_cpu_wdata,
        output i_dma_req, output i_dma_we, output i_dma_lock, output i_dma_addr, output i_dma_wdata,
        output i_ram_rdata,
        input  o_cpu_rdata, input o_cpu_gnt, input o_cpu_stall,
        input  o_dma_rdata, input o_dma_rvalid, input o_dma_gnt,
        input  o_ram_addr, input o_ram_wdata, input o_ram_we
`ifdef DMEM_ARB_STATS_EN
        , input o_cpu_cnt, input o_dma_cnt, input o_stall_cnt
`endif
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data RAM arbiter: CPU priority with DMA starvation counter and burst lock.
// Optional statistics counters enabled by defining DMEM_ARB_STATS_EN.
module dmem_arbiter #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input logic           i_clk,
    input logic           i_rst_n,
    dmem_arbiter_if.slave bus
);
    localparam logic [0:0] ST_CPU  = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;
    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    logic [0:0]        state;
    logic [3:0]        wait_cnt;
    logic              cpu_gnt;
    logic              dma_gnt;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [DATA_W-1:0] dma_rdata_q;
    logic              dma_rvalid_q;

    // Grants are held low throughout reset so nothing reaches the RAM.
    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (i_rst_n) begin
            if (state == ST_LOCK) begin
                dma_gnt = bus.i_dma_req;
            end else if (bus.i_dma_req && (!bus.i_cpu_req || wait_cnt == WAIT_MAX)) begin
                dma_gnt = 1'b1;
            end else begin
                cpu_gnt = bus.i_cpu_req;
            end
        end
    end

    always_comb begin
        ram_addr  = bus.i_cpu_addr;
        ram_wdata = bus.i_cpu_wdata;
        ram_we    = cpu_gnt & bus.i_cpu_we;
        if (dma_gnt) begin
            ram_addr  = bus.i_dma_addr;
            ram_wdata = bus.i_dma_wdata;
            ram_we    = bus.i_dma_we;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state        <= ST_CPU;
            wait_cnt     <= '0;
            dma_rdata_q  <= '0;
            dma_rvalid_q <= 1'b0;
        end else begin
            if (state == ST_CPU && dma_gnt && bus.i_dma_lock) begin
                state <= ST_LOCK;
            end else if (state == ST_LOCK && !bus.i_dma_lock) begin
                state <= ST_CPU;
            end

            if (!bus.i_dma_req || dma_gnt) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + 4'd1;
            end

            dma_rvalid_q <= dma_gnt & ~bus.i_dma_we;
            if (dma_gnt && !bus.i_dma_we) begin
                dma_rdata_q <= bus.i_ram_rdata;
            end
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] cpu_cnt;
    logic [15:0] dma_cnt;
    logic [15:0] stall_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cpu_cnt   <= '0;
            dma_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if (cpu_gnt) cpu_cnt <= cpu_cnt + 16'd1;
            if (dma_gnt) dma_cnt <= dma_cnt + 16'd1;
            if (bus.i_cpu_req && !cpu_gnt) stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign bus.o_cpu_cnt   = cpu_cnt;
    assign bus.o_dma_cnt   = dma_cnt;
    assign bus.o_stall_cnt = stall_cnt;
`endif

    assign bus.o_cpu_gnt    = cpu_gnt;
    assign bus.o_dma_gnt    = dma_gnt;
    assign bus.o_cpu_stall  = bus.i_cpu_req & ~cpu_gnt;
    assign bus.o_cpu_rdata  = cpu_gnt ? bus.i_ram_rdata : '0;
    assign bus.o_dma_rdata  = dma_rdata_q;
    assign bus.o_dma_rvalid = dma_rvalid_q;
    assign bus.o_ram_addr   = ram_addr;
    assign bus.o_ram_wdata  = ram_wdata;
    assign bus.o_ram_we     = ram_we;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural arbitration/memory model.
module tb_dmem_arbiter;
    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    // Environment RAM seen by the DUT
    logic [31:0] ram [128];
    always @(posedge clk) if (bus.o_ram_we === 1'b1) ram[bus.o_ram_addr] <= bus.o_ram_wdata;
    assign bus.i_ram_rdata = ram[bus.o_ram_addr];

    typedef struct {
        logic        cg, dg, st, we, rv;
        logic [6:0]  addr;
        logic [31:0] wd, crd;
        logic [15:0] cc, dc, sc;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] rd_q  [$];
    int tests = 0;
    int fails = 0;
    int mon_dma = 0;
    int mon_cpu = 0;

    // Reference model state
    logic [31:0] ref_mem [128];
    bit          m_locked;
    int          m_denied;
    bit          m_prev_rd;
    logic [15:0] m_cc, m_dc, m_sc;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    task automatic cycle(input bit rst, input bit cr, input bit cw, input logic [6:0] ca,
                         input logic [31:0] cwd, input bit dr, input bit dw, input bit dl,
                         input logic [6:0] da, input logic [31:0] dwd,
                         output bit gc, output bit gd);
        exp_t e;
        rst_n = rst;
        bus.i_cpu_req = cr;  bus.i_cpu_we = cw;  bus.i_cpu_addr = ca;  bus.i_cpu_wdata = cwd;
        bus.i_dma_req = dr;  bus.i_dma_we = dw;  bus.i_dma_lock = dl;
        bus.i_dma_addr = da; bus.i_dma_wdata = dwd;
        gc = 1'b0;
        gd = 1'b0;
        if (rst) begin
            if (m_locked) gd = dr;
            else if (dr && (!cr || m_denied >= MAX_WAIT)) gd = 1'b1;
            else gc = cr;
        end
        e.cg   = gc;
        e.dg   = gd;
        e.st   = cr && !gc;
        e.we   = (gc && cw) || (gd && dw);
        e.addr = gd ? da : ca;
        e.wd   = gd ? dwd : cwd;
        e.crd  = gc ? ref_mem[ca] : 32'h0;
        e.rv   = m_prev_rd;
        e.cc   = m_cc;
        e.dc   = m_dc;
        e.sc   = m_sc;
        exp_q.push_back(e);
        if (gd && !dw) rd_q.push_back(ref_mem[da]);
        if (gc && cw) ref_mem[ca] = cwd;
        if (gd && dw) ref_mem[da] = dwd;
        if (!rst) begin
            m_locked = 0; m_denied = 0; m_prev_rd = 0;
            m_cc = '0; m_dc = '0; m_sc = '0;
        end else begin
            m_prev_rd = gd && !dw;
            m_cc = m_cc + 16'(gc);
            m_dc = m_dc + 16'(gd);
            m_sc = m_sc + 16'(e.st);
            m_locked = m_locked ? dl : (gd && dl);
            if (dr && !gd) m_denied = (m_denied < MAX_WAIT) ? m_denied + 1 : MAX_WAIT;
            else m_denied = 0;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares each presented cycle and every DMA read return
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("cpu_gnt",   32'(bus.o_cpu_gnt),   32'(e.cg));
            chk("dma_gnt",   32'(bus.o_dma_gnt),   32'(e.dg));
            chk("cpu_stall", 32'(bus.o_cpu_stall), 32'(e.st));
            chk("ram_we",    32'(bus.o_ram_we),    32'(e.we));
            chk("ram_addr",  32'(bus.o_ram_addr),  32'(e.addr));
            chk("ram_wdata", bus.o_ram_wdata,      e.wd);
            chk("cpu_rdata", bus.o_cpu_rdata,      e.crd);
            chk("dma_rvalid", 32'(bus.o_dma_rvalid), 32'(e.rv));
`ifdef DMEM_ARB_STATS_EN
            chk("cpu_cnt",   32'(bus.o_cpu_cnt),   32'(e.cc));
            chk("dma_cnt",   32'(bus.o_dma_cnt),   32'(e.dc));
            chk("stall_cnt", 32'(bus.o_stall_cnt), 32'(e.sc));
`endif
            if (bus.o_dma_gnt === 1'b1) mon_dma++;
            if (bus.o_cpu_gnt === 1'b1) mon_cpu++;
        end
        if (bus.o_dma_rvalid === 1'b1) begin
            if (rd_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL dma_rvalid_unexpected: got rvalid=1 expected no pending read at %0t", $time);
            end else begin
                chk("dma_rdata", bus.o_dma_rdata, rd_q.pop_front());
            end
        end
    end

    bit g0, g1;
    int base_d, base_c, beat, guard;

    initial begin
        for (int i = 0; i < 128; i++) begin
            ram[i] = $urandom;
            ref_mem[i] = ram[i];
        end
        ram[127] = 32'h1234_5678;
        ref_mem[127] = 32'h1234_5678;
        m_locked = 0; m_denied = 0; m_prev_rd = 0;
        m_cc = '0; m_dc = '0; m_sc = '0;
        bus.i_cpu_req = 0; bus.i_cpu_we = 0; bus.i_cpu_addr = '0; bus.i_cpu_wdata = '0;
        bus.i_dma_req = 0; bus.i_dma_we = 0; bus.i_dma_lock = 0;
        bus.i_dma_addr = '0; bus.i_dma_wdata = '0;
        @(posedge clk);
        #1;

        // Reset with both ports requesting: no grants, no RAM write
        cycle(0, 1, 1, 7'd1, 32'h1, 1, 1, 1, 7'd2, 32'h2, g0, g1);

        // Contention from a clean reset: 4 CPU : 1 DMA
        base_d = mon_dma;
        base_c = mon_cpu;
        for (int i = 0; i < 10; i++)
            cycle(1, 1, 0, 7'($urandom), 32'h0, 1, 0, 0, 7'($urandom), 32'h0, g0, g1);
        chk("contention_dma_grants", 32'(mon_dma - base_d), 32'd2);
        chk("contention_cpu_grants", 32'(mon_cpu - base_c), 32'd8);
`ifdef DMEM_ARB_STATS_EN
        chk("stats_cpu_cnt_10",   32'(bus.o_cpu_cnt),   32'd8);
        chk("stats_dma_cnt_10",   32'(bus.o_dma_cnt),   32'd2);
        chk("stats_stall_cnt_10", 32'(bus.o_stall_cnt), 32'd2);
`endif

        // CPU-only store then load
        cycle(1, 0, 0, 7'd0, 32'h0, 0, 0, 0, 7'd0, 32'h0, g0, g1);
        cycle(1, 1, 1, 7'd5, 32'hDEAD_BEEF, 0, 0, 0, 7'd0, 32'h0, g0, g1);
        cycle(1, 1, 0, 7'd5, 32'h0, 0, 0, 0, 7'd0, 32'h0, g0, g1);

        // DMA read of 0x7F with CPU idle, then two idle cycles
        cycle(1, 0, 0, 7'd0, 32'h0, 1, 0, 0, 7'h7F, 32'h0, g0, g1);
        cycle(1, 0, 0, 7'd0, 32'h0, 0, 0, 0, 7'd0, 32'h0, g0, g1);
        cycle(1, 0, 0, 7'd0, 32'h0, 0, 0, 0, 7'd0, 32'h0, g0, g1);

        // Burst lock: four DMA write beats, CPU requesting throughout
        beat = 0;
        guard = 0;
        while (beat < 4 && guard < 20) begin
            cycle(1, 1, 0, 7'd10, 32'h0, 1, 1, beat < 3, 7'(beat), $urandom, g0, g1);
            if (g1) beat++;
            guard++;
        end
        chk("burst_beats_done", 32'(beat), 32'd4);
        cycle(1, 1, 0, 7'd0, 32'h0, 0, 0, 0, 7'd0, 32'h0, g0, g1);
        cycle(1, 1, 0, 7'd1, 32'h0, 0, 0, 0, 7'd0, 32'h0, g0, g1);

        // Reset mid-lock drops the lock; CPU wins afterwards
        cycle(1, 0, 0, 7'd0, 32'h0, 1, 1, 1, 7'd20, 32'hA5A5_0001, g0, g1);
        cycle(1, 1, 0, 7'd3, 32'h0, 1, 1, 1, 7'd21, 32'hA5A5_0002, g0, g1);
        cycle(0, 1, 0, 7'd3, 32'h0, 1, 1, 1, 7'd22, 32'hA5A5_0003, g0, g1);
        cycle(1, 1, 0, 7'd3, 32'h0, 1, 1, 1, 7'd23, 32'hA5A5_0004, g0, g1);
        chk("post_reset_cpu_wins", 32'(g0), 32'd1);

        // Randomized traffic with occasional resets and locks
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(99) != 0,
                  $urandom_range(3) != 0, $urandom_range(1) == 1, 7'($urandom), $urandom,
                  $urandom_range(2) != 0, $urandom_range(1) == 1, $urandom_range(3) == 0,
                  7'($urandom), $urandom, g0, g1);
        end

        for (int i = 0; i < 3; i++)
            cycle(1, 0, 0, 7'd0, 32'h0, 0, 0, 0, 7'd0, 32'h0, g0, g1);

        chk("scoreboard_drained", 32'(exp_q.size() + rd_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data RAM (128 x 32, 7-bit word address, synchronous write, combinational read) between two requesters.
- Requester 0 is the pipeline MEM stage (CPU). Requester 1 is the loader/DMA port used for program/data preload and debug readback.
- Grant is decided in the same cycle as the request. The CPU has priority; a starvation counter and a burst lock give the DMA port guaranteed progress.
- Sits between the MEM stage and the RAM instance. Drives a stall back to the hazard unit.

Parameters:
- ADDR_W, 7, RAM word-address width.
- DATA_W, 32, data width.
- MAX_WAIT, 4, consecutive denied DMA request cycles before the DMA port is forced a grant (range 1..15).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous active-low reset
- i_cpu_req  in  1  CPU access request (load or store)
- i_cpu_we  in  1  CPU write enable (1 = store)
- i_cpu_addr  in  ADDR_W  CPU word address
- i_cpu_wdata  in  DATA_W  CPU store data
- o_cpu_rdata  out  DATA_W  CPU load data, valid when o_cpu_gnt is high
- o_cpu_gnt  out  1  CPU access performed this cycle
- o_cpu_stall  out  1  = i_cpu_req & ~o_cpu_gnt
- i_dma_req  in  1  DMA access request
- i_dma_we  in  1  DMA write enable
- i_dma_lock  in  1  DMA holds ownership after the current beat
- i_dma_addr  in  ADDR_W  DMA word address
- i_dma_wdata  in  DATA_W  DMA write data
- o_dma_rdata  out  DATA_W  registered DMA read data
- o_dma_rvalid  out  1  o_dma_rdata valid (one cycle after the granted read)
- o_dma_gnt  out  1  DMA access performed this cycle
- o_ram_addr  out  ADDR_W  to RAM address
- o_ram_wdata  out  DATA_W  to RAM write data
- o_ram_we  out  1  to RAM write enable
- i_ram_rdata  in  DATA_W  from RAM read data

Behaviour:
- States: ST_CPU (CPU priority, reset state) and ST_LOCK (DMA owns the RAM).
- ST_CPU grant rule, evaluated combinationally each cycle:
  - DMA is granted if i_dma_req & (~i_cpu_req | wait_cnt == MAX_WAIT).
  - Otherwise the CPU is granted if i_cpu_req.
  - At most one grant per cycle.
- ST_LOCK: DMA is granted if i_dma_req. The CPU is never granted; o_cpu_stall follows i_cpu_req.
- Transitions:
  - ST_CPU -> ST_LOCK on a DMA grant with i_dma_lock = 1.
  - ST_LOCK -> ST_CPU on any cycle with i_dma_lock = 0. The beat in that cycle, if any, is still granted.
  - ST_LOCK holds while the lock stays high, even with i_dma_req low.
- wait_cnt (4-bit):
  - Increments when i_dma_req & ~o_dma_gnt, saturating at MAX_WAIT.
  - Clears on a DMA grant or when i_dma_req = 0.
- RAM mux:
  - Address, wdata and we come from the granted port.
  - With no grant: o_ram_we = 0, address/wdata = CPU values.
  - o_ram_we = granted port's we & grant.
- CPU read: o_cpu_rdata = i_ram_rdata combinationally (zero latency, matching the single-cycle MEM stage). When o_cpu_gnt = 0, o_cpu_rdata = 0.
- DMA read: on a granted DMA read (gnt & ~we), i_ram_rdata is registered into o_dma_rdata and o_dma_rvalid = 1 the next cycle. o_dma_rvalid is a 1-cycle pulse; o_dma_rdata holds its value until the next DMA read.
- Writes complete at the clock edge of the grant cycle. A read of the same address on the next cycle returns the new data.
- Reset (i_rst_n low at a posedge):
  - State = ST_CPU, wait_cnt = 0.
  - o_dma_rdata = 0, o_dma_rvalid = 0, stats counters = 0.
  - While i_rst_n is low, grants and o_ram_we are forced to 0.
  - Reset asserted mid-lock drops the lock.
- Boundary conditions:
  - Requests with both ports idle: no RAM write.
  - Simultaneous requests in ST_CPU with wait_cnt < MAX_WAIT: CPU wins.
  - An address collision between ports is irrelevant, since only one port is ever granted.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined: adds outputs o_cpu_cnt and o_dma_cnt (16 bits each, wrap-around). Each increments on its port's grant; both clear on reset.
- Also adds o_stall_cnt (16 bits), which increments on every cycle o_cpu_stall = 1.
- Not defined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- CPU-only traffic: store 0xDEADBEEF to addr 5, then load addr 5 -> o_cpu_gnt = 1 both cycles, o_cpu_stall = 0, o_cpu_rdata = 0xDEADBEEF on the load cycle.
- Contention, MAX_WAIT = 4: both requests held high continuously -> CPU granted cycles 0-3, DMA granted cycle 4 with o_cpu_stall = 1 that cycle, then the pattern repeats (4 CPU : 1 DMA).
- DMA read: DMA reads addr 0x7F containing 0x12345678 with the CPU idle -> o_dma_gnt in cycle N; o_dma_rvalid = 1 and o_dma_rdata = 0x12345678 in cycle N+1; rvalid = 0 in N+2.
- Burst lock: DMA writes addrs 0-3 with i_dma_lock = 1 on beats 0-2 and 0 on beat 3, CPU requesting throughout -> four consecutive DMA grants, o_cpu_stall = 1 for those 4 cycles, CPU granted on cycle 5.
- Reset mid-lock: enter ST_LOCK, then pull i_rst_n low for 1 cycle with both ports requesting -> no grants and o_ram_we = 0 during reset; after reset the CPU wins with wait_cnt = 0.
- With DMEM_ARB_STATS_EN defined: run the contention test for 10 cycles -> o_cpu_cnt = 8, o_dma_cnt = 2, o_stall_cnt = 2.
